raven_mem_decoder: RTL and testbench

Address decoder and chip-select generator for the 68000 bus of the Raven68k board (CPLD v1). Decodes /AS, /UDS, /LDS and address lines A21, A17, A9–A7 into active-low byte-lane selects for RAM and ROM and a select for the DUART. After reset it overlays ROM onto the whole map for the first eight bus cycles so the CPU fetches its reset vectors from ROM.

---
 rtl/raven_bus_pkg.sv | 17 +
 rtl/boot_overlay.sv | 47 ++++
 rtl/raven_mem_decoder.sv | 87 ++++++++
 tb/tb_raven_mem_decoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/raven_bus_pkg.sv
// Shared definitions for the Raven68k bus decode logic.
//   region_e    : decoded address region of the current bus cycle
//   BOOT_CYCLES : default number of /AS cycles during which ROM overlays the map
//   DUART_SEL   : default {a9,a8,a7} value selecting the DUART within I/O space
package raven_bus_pkg;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_ROM,
    REG_IO
  } region_e;

  localparam int         BOOT_CYCLES = 8;
  localparam logic [2:0] DUART_SEL   = 3'b000;

endpackage

// File: rtl/boot_overlay.sv
// Boot-time ROM overlay tracker.
// Counts completed /AS cycles after reset and reports whether the ROM overlay
// is still in force.
//   clk            : in,  system clock
//   reset          : in,  synchronous active-high reset
//   as             : in,  CPU address strobe, active low
//   overlay_active : out, high while fewer than BOOT_CYCLES cycles have completed
module boot_overlay #(
  parameter int BOOT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic as,
  output logic overlay_active
);

  localparam int CNT_W = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;

  // Down-counter of cycles still to be overlaid; zero is the terminal count,
  // which also gives the saturation for free.
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             as_q, as_d;
  logic             cycle_done;

  always_comb begin
    as_d       = as;
    remain_d   = remain_q;
    // A cycle ends when /AS is seen high after being seen low on the prior edge.
    cycle_done = as && !as_q;
    if (cycle_done && (remain_q != '0)) begin
      remain_d = remain_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remain_q <= CNT_W'(BOOT_CYCLES);
      as_q     <= 1'b1;
    end else begin
      remain_q <= remain_d;
      as_q     <= as_d;
    end
  end

  assign overlay_active = (remain_q != '0);

endmodule

// File: rtl/raven_mem_decoder.sv
// Raven68k address decoder and chip-select generator.
// Decodes /AS, /UDS, /LDS, A21, A17 and A9..A7 into active-low selects.
//   clk, reset              : system clock, synchronous active-high reset
//   a7, a8, a9              : I/O sub-decode address bits
//   a17                     : ROM (0) / I/O (1) within the upper half
//   a21                     : RAM (0) / ROM+I/O (1)
//   as, uds, lds            : CPU address and data strobes, active low
//   ram_evn_cs, ram_odd_cs  : RAM byte-lane selects, active low
//   rom_evn_cs, rom_odd_cs  : ROM byte-lane selects, active low
//   duart_cs                : DUART select, active low
module raven_mem_decoder #(
  parameter int         BOOT_CYCLES = raven_bus_pkg::BOOT_CYCLES,
  parameter logic [2:0] DUART_SEL   = raven_bus_pkg::DUART_SEL
) (
  input  logic clk,
  input  logic reset,
  input  logic a7,
  input  logic a8,
  input  logic a9,
  input  logic a17,
  input  logic a21,
  input  logic as,
  input  logic uds,
  input  logic lds,
  output logic ram_evn_cs,
  output logic ram_odd_cs,
  output logic rom_evn_cs,
  output logic rom_odd_cs,
  output logic duart_cs
);

  import raven_bus_pkg::*;

  logic    overlay_active;
  region_e region;

  boot_overlay #(
    .BOOT_CYCLES (BOOT_CYCLES)
  ) u_boot_overlay (
    .clk            (clk),
    .reset          (reset),
    .as             (as),
    .overlay_active (overlay_active)
  );

  always_comb begin
    region = REG_NONE;
    if (!reset && !as) begin
      if (overlay_active) begin
        region = REG_ROM;
      end else if (!a21) begin
        region = REG_RAM;
      end else if (!a17) begin
        region = REG_ROM;
      end else begin
        region = REG_IO;
      end
    end
  end

  // Strobes are active low, so a lane select simply follows its strobe once
  // the region matches; everything else stays deasserted high.
  always_comb begin
    ram_evn_cs = 1'b1;
    ram_odd_cs = 1'b1;
    rom_evn_cs = 1'b1;
    rom_odd_cs = 1'b1;
    duart_cs   = 1'b1;
    unique case (region)
      REG_RAM: begin
        ram_evn_cs = uds;
        ram_odd_cs = lds;
      end
      REG_ROM: begin
        rom_evn_cs = uds;
        rom_odd_cs = lds;
      end
      REG_IO: begin
        if ({a9, a8, a7} == DUART_SEL) begin
          duart_cs = uds && lds;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_raven_mem_decoder.sv
module tb_raven_mem_decoder;

  localparam int BOOT = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a7 = 1'b0, a8 = 1'b0, a9 = 1'b0, a17 = 1'b0, a21 = 1'b0;
  logic as = 1'b1, uds = 1'b1, lds = 1'b1;
  logic ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs;
  logic [4:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: number of completed /AS cycles since reset.
  int   m_cnt = 0;
  logic m_as_prev = 1'b1;

  raven_mem_decoder #(
    .BOOT_CYCLES (BOOT),
    .DUART_SEL   (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a7         (a7),
    .a8         (a8),
    .a9         (a9),
    .a17        (a17),
    .a21        (a21),
    .as         (as),
    .uds        (uds),
    .lds        (lds),
    .ram_evn_cs (ram_evn_cs),
    .ram_odd_cs (ram_odd_cs),
    .rom_evn_cs (rom_evn_cs),
    .rom_odd_cs (rom_odd_cs),
    .duart_cs   (duart_cs)
  );

  always #5 clk = ~clk;

  assign obs = {ram_evn_cs, ram_odd_cs, rom_evn_cs, rom_odd_cs, duart_cs};

  always @(posedge clk) begin
    if (reset) begin
      m_cnt     <= 0;
      m_as_prev <= 1'b1;
    end else begin
      if (as && !m_as_prev && m_cnt < BOOT) m_cnt <= m_cnt + 1;
      m_as_prev <= as;
    end
  end

  // Expected {ram_evn, ram_odd, rom_evn, rom_odd, duart}, all active low.
  function automatic logic [4:0] exp_cs(input int cnt, input logic r, input logic s,
                                        input logic u, input logic l, input logic h21,
                                        input logic h17, input logic [2:0] sel);
    logic [4:0] e;
    e = 5'b11111;
    if (!r && !s) begin
      if (cnt < BOOT || (h21 && !h17)) begin
        e[2] = u;
        e[1] = l;
      end else if (!h21) begin
        e[4] = u;
        e[3] = l;
      end else if (sel == 3'd0 && (!u || !l)) begin
        e[0] = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic drive_bus(input logic s, input logic u, input logic l,
                           input logic h21, input logic h17, input logic [2:0] sel);
    @(negedge clk);
    as  = s;
    uds = u;
    lds = l;
    a21 = h21;
    a17 = h17;
    {a9, a8, a7} = sel;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    as = 1'b0; uds = 1'b0; lds = 1'b0; a21 = 1'b0; a17 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (obs !== 5'b11111) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs, 5'b11111);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    as = 1'b1;
    #1;
    tests_run++;
    if (obs !== 5'b11111) begin
      tests_failed++;
      $display("FAIL reset_release: got %b expected %b", obs, 5'b11111);
    end
  endtask

  task automatic test_boot_overlay();
    logic [4:0] want;
    for (int p = 1; p <= 10; p++) begin
      drive_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
      want = (p <= BOOT) ? 5'b11001 : 5'b11110;
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL boot_pulse%0d: got %b expected %b", p, obs, want);
      end
      drive_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
      tests_run++;
      if (obs !== 5'b11111) begin
        tests_failed++;
        $display("FAIL boot_idle%0d: got %b expected %b", p, obs, 5'b11111);
      end
    end
  endtask

  task automatic test_ram_lanes();
    logic [1:0]  strobes [3] = '{2'b10, 2'b01, 2'b00};
    logic [4:0]  want    [3] = '{5'b10111, 5'b01111, 5'b00111};
    for (int i = 0; i < 3; i++) begin
      drive_bus(1'b0, strobes[i][1], strobes[i][0], 1'b0, 1'b0, 3'b101);
      tests_run++;
      if (obs !== want[i]) begin
        tests_failed++;
        $display("FAIL ram_lane%0d: got %b expected %b", i, obs, want[i]);
      end
      drive_bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101);
    end
  endtask

  task automatic test_rom_lanes();
    logic [1:0]  strobes [3] = '{2'b10, 2'b01, 2'b00};
    logic [4:0]  want    [3] = '{5'b11101, 5'b11011, 5'b11001};
    for (int i = 0; i < 3; i++) begin
      drive_bus(1'b0, strobes[i][1], strobes[i][0], 1'b1, 1'b0, 3'b000);
      tests_run++;
      if (obs !== want[i]) begin
        tests_failed++;
        $display("FAIL rom_lane%0d: got %b expected %b", i, obs, want[i]);
      end
      drive_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
    end
  endtask

  task automatic test_io();
    logic [1:0] strobes [3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drive_bus(1'b0, strobes[i][1], strobes[i][0], 1'b1, 1'b1, 3'b000);
      tests_run++;
      if (obs !== 5'b11110) begin
        tests_failed++;
        $display("FAIL io_duart%0d: got %b expected %b", i, obs, 5'b11110);
      end
      drive_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
    end
    for (int s = 1; s < 8; s++) begin
      drive_bus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'(s));
      tests_run++;
      if (obs !== 5'b11111) begin
        tests_failed++;
        $display("FAIL io_sub%0d: got %b expected %b", s, obs, 5'b11111);
      end
      drive_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
    end
    drive_bus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
    tests_run++;
    if (obs !== 5'b11111) begin
      tests_failed++;
      $display("FAIL io_as_high: got %b expected %b", obs, 5'b11111);
    end
    drive_bus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
    tests_run++;
    if (obs !== 5'b11111) begin
      tests_failed++;
      $display("FAIL io_no_strobe: got %b expected %b", obs, 5'b11111);
    end
    drive_bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
  endtask

  task automatic test_random();
    logic [4:0] want;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      reset = ($urandom_range(15, 0) == 0);
      as    = 1'($urandom_range(1, 0));
      uds   = 1'($urandom_range(1, 0));
      lds   = 1'($urandom_range(1, 0));
      a21   = 1'($urandom_range(1, 0));
      a17   = 1'($urandom_range(1, 0));
      {a9, a8, a7} = ($urandom_range(1, 0) == 1) ? 3'b000 : 3'($urandom_range(7, 0));
      #1;
      want = exp_cs(m_cnt, reset, as, uds, lds, a21, a17, {a9, a8, a7});
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL random%0d: got %b expected %b (cnt %0d)", i, obs, want, m_cnt);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    as = 1'b1;
  endtask

  task automatic test_reset_midway();
    logic [4:0] want;
    @(negedge clk);
    reset = 1'b1;
    as = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int p = 0; p < 3; p++) begin
      drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      drive_bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    end
    drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    tests_run++;
    if (obs !== 5'b11001) begin
      tests_failed++;
      $display("FAIL midway_overlay: got %b expected %b", obs, 5'b11001);
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (obs !== 5'b11111) begin
        tests_failed++;
        $display("FAIL midway_reset%0d: got %b expected %b", i, obs, 5'b11111);
      end
      @(negedge clk);
      #1;
    end
    reset = 1'b0;
    as = 1'b1;
    for (int p = 1; p <= 9; p++) begin
      drive_bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
      want = (p <= BOOT) ? 5'b11001 : 5'b00111;
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("FAIL midway_pulse%0d: got %b expected %b", p, obs, want);
      end
      drive_bus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    end
  endtask

  initial begin
    test_reset();
    test_boot_overlay();
    test_ram_lanes();
    test_rom_lanes();
    test_io();
    test_random();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
